// File: rtl/rf_wb_pkg.sv
// Shared constants and entry type for the register-file writeback queue.
// Default widths match the RegisterFile: 32 registers of 32 bits.
package rf_wb_pkg;

    localparam int RF_WB_DEPTH  = 4;
    localparam int RF_WB_ADDR_W = 5;
    localparam int RF_WB_DATA_W = 32;

    typedef struct packed {
        logic [RF_WB_ADDR_W-1:0] rd;
        logic [RF_WB_DATA_W-1:0] data;
    } rf_wb_entry_t;

endpackage

// File: rtl/rf_wb_match.sv
// Youngest-match priority search over the pending writeback entries.
// Slot 0 is the oldest entry and slot DEPTH-1 the youngest; register 0 never matches.
module rf_wb_match
    import rf_wb_pkg::*;
#(
    parameter int DEPTH  = RF_WB_DEPTH,
    parameter int ADDR_W = RF_WB_ADDR_W,
    parameter int DATA_W = RF_WB_DATA_W
) (
    input  logic [ADDR_W-1:0]             key,
    input  logic [DEPTH-1:0]              valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  rds,
    input  logic [DEPTH-1:0][DATA_W-1:0]  datas,
    output logic                          hit,
    output logic [DATA_W-1:0]             data
);

    logic [DEPTH-1:0] match_vec;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign match_vec[gi] = valid[gi] && (rds[gi] == key) && (key != '0);
    end

    // Later (younger) slots overwrite earlier ones, so the youngest match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_vec[i]) begin
                hit  = 1'b1;
                data = datas[i];
            end
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// Writeback FIFO in front of the RegisterFile write port, draining one entry per clock.
// Define RFWQ_BYPASS_EN to build the rs/rt bypass CAM; otherwise the bypass outputs are tied to zero.
module rf_writeback_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH  = RF_WB_DEPTH,
    parameter int ADDR_W = RF_WB_ADDR_W,
    parameter int DATA_W = RF_WB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_in,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              byp1_hit,
    output logic [DATA_W-1:0] byp1_data,
    output logic              byp2_hit,
    output logic [DATA_W-1:0] byp2_data,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_rd   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;

    logic push;
    logic pop;

    assign wb_ready = (count_reg != CNT_W'(DEPTH));
    // Writes to $zero complete the handshake but are dropped here.
    assign push     = wb_valid && wb_ready && (wb_rd != '0);
    assign pop      = (count_reg != '0);
    assign empty    = !pop;

    assign rf_we = pop;
    assign rf_rd = pop ? mem_rd[rd_ptr_reg]   : '0;
    assign rf_in = pop ? mem_data[rd_ptr_reg] : '0;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Payload storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr_reg]   <= wb_rd;
            mem_data[wr_ptr_reg] <= wb_data;
        end
    end

`ifdef RFWQ_BYPASS_EN
    logic [DEPTH-1:0]             ord_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ord_rd;
    logic [DEPTH-1:0][DATA_W-1:0] ord_data;

    // Re-order storage oldest-first so the matcher can prioritise by slot index.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ord
        logic [PTR_W-1:0] slot;
        assign slot          = rd_ptr_reg + PTR_W'(gi);
        assign ord_valid[gi] = (CNT_W'(gi) < count_reg);
        assign ord_rd[gi]    = mem_rd[slot];
        assign ord_data[gi]  = mem_data[slot];
    end

    rf_wb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match_rs (
        .key   (rs),
        .valid (ord_valid),
        .rds   (ord_rd),
        .datas (ord_data),
        .hit   (byp1_hit),
        .data  (byp1_data)
    );

    rf_wb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match_rt (
        .key   (rt),
        .valid (ord_valid),
        .rds   (ord_rd),
        .datas (ord_data),
        .hit   (byp2_hit),
        .data  (byp2_data)
    );
`else
    logic unused_rs_rt;
    assign unused_rs_rt = ^{rs, rt};

    assign byp1_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_hit  = 1'b0;
    assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue: stimulus queues expected RF writes, a monitor checks the write port.
// Bypass expectations follow RFWQ_BYPASS_EN.
module tb_rf_writeback_queue;
    import rf_wb_pkg::*;

    localparam int AW = RF_WB_ADDR_W;
    localparam int DW = RF_WB_DATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [AW-1:0] wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_in;
    logic [AW-1:0] rs = '0;
    logic [AW-1:0] rt = '0;
    logic          byp1_hit, byp2_hit;
    logic [DW-1:0] byp1_data, byp2_data;
    logic          empty;

    int checks = 0;
    int failures = 0;

    rf_wb_entry_t exp_q[$];
    logic [DW-1:0] rf_model [32] = '{default: '0};

    rf_writeback_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_in     (rf_in),
        .rs        (rs),
        .rt        (rt),
        .byp1_hit  (byp1_hit),
        .byp1_data (byp1_data),
        .byp2_hit  (byp2_hit),
        .byp2_data (byp2_data),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Behavioural RegisterFile fed by the DUT write port.
    always @(posedge clk) begin
        if (rst_n && rf_we && rf_rd != '0) begin
            rf_model[rf_rd] <= rf_in;
        end
    end

    // Monitor: each cycle the write port must present exactly the next expected write, or nothing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                chk("mon_idle_we", DW'(rf_we), DW'(0));
            end else begin
                rf_wb_entry_t e;
                e = exp_q.pop_front();
                chk("mon_we", DW'(rf_we), DW'(1));
                chk("mon_rd", DW'(rf_rd), DW'(e.rd));
                chk("mon_in", rf_in, e.data);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that takes the handshake.
    task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        logic accepted;
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        #1;
        chk("wb_ready", DW'(wb_ready), DW'(1));
        accepted = wb_ready;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        if (accepted && rd != '0) begin
            rf_wb_entry_t e;
            e.rd   = rd;
            e.data = data;
            exp_q.push_back(e);
        end
    endtask

    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_we_async", DW'(rf_we), DW'(0));
        chk("rst_empty_async", DW'(empty), DW'(1));
        chk("rst_rf_in_zero", rf_in, DW'(0));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_empty", DW'(empty), DW'(1));
            chk("idle_ready", DW'(wb_ready), DW'(1));
            chk("idle_we", DW'(rf_we), DW'(0));
        end
        @(posedge clk);
        #1;
        push(5'd3, 32'h11);
        chk("pre_rst_we", DW'(rf_we), DW'(1));
        async_reset_pulse();
        chk("rst_no_commit_r3", rf_model[3], DW'(0));

        // 2. single write latency
        push(5'd4, 32'd9);
        chk("t2_we", DW'(rf_we), DW'(1));
        chk("t2_rd", DW'(rf_rd), DW'(4));
        chk("t2_in", rf_in, DW'(9));
        @(posedge clk);
        #1;
        chk("t2_rf4", rf_model[4], DW'(9));
        chk("t2_empty", DW'(empty), DW'(1));

        // 3. $zero write is swallowed
        push(5'd0, 32'd5);
        chk("t3_we", DW'(rf_we), DW'(0));
        chk("t3_empty", DW'(empty), DW'(1));

        // 4. back-to-back pushes drain in order
        for (int i = 1; i <= 5; i++) begin
            push(AW'(i), DW'(32'h100 + i));
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t4_rf5", rf_model[5], DW'(32'h105));
        chk("t4_empty", DW'(empty), DW'(1));

        // 5. bypass picks the youngest pending value
        push(5'd7, 32'd2);
        push(5'd7, 32'd3);
        rs = 5'd7;
        rt = 5'd6;
        #1;
`ifdef RFWQ_BYPASS_EN
        chk("t5_byp1_hit", DW'(byp1_hit), DW'(1));
        chk("t5_byp1_data", byp1_data, DW'(3));
`else
        chk("t5_byp1_hit", DW'(byp1_hit), DW'(0));
        chk("t5_byp1_data", byp1_data, DW'(0));
`endif
        chk("t5_byp2_hit", DW'(byp2_hit), DW'(0));
        chk("t5_byp2_data", byp2_data, DW'(0));
        @(posedge clk);
        #1;
        chk("t5_byp1_after_drain", DW'(byp1_hit), DW'(0));
        chk("t5_rf7", rf_model[7], DW'(3));

        // 6. reset with writes pending discards them
        push(5'd10, 32'd100);
        push(5'd11, 32'd101);
        push(5'd12, 32'd102);
        async_reset_pulse();
        repeat (3) @(negedge clk);
        chk("t6_we", DW'(rf_we), DW'(0));
        chk("t6_rf11", rf_model[11], DW'(101));
        chk("t6_rf12_stale", rf_model[12], DW'(0));
        chk("t6_ready", DW'(wb_ready), DW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout: bench did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
